// File: rtl/pc_unit_if.sv
// Fetch-side bundle for pc_unit: stall/redirect/trap requests in, PC and RAS status out.
interface pc_unit_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
);

  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  logic            stall;
  logic            redirect_valid;
  logic [1:0]      redirect_kind;
  logic [XLEN-1:0] redirect_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus;
  logic            pc_valid;
  logic            misalign_err;
  logic [XLEN-1:0] misalign_addr;
  logic            ras_overflow;
  logic            ras_underflow;
  logic [CntW-1:0] ras_count;

  // Branch/trap logic side: issues requests, observes the PC.
  modport master (
    output stall, redirect_valid, redirect_kind, redirect_target, trap_valid, trap_vector,
    input  pc_out, pc_plus, pc_valid, misalign_err, misalign_addr, ras_overflow,
    input  ras_underflow, ras_count
  );

  // PC unit side.
  modport slave (
    input  stall, redirect_valid, redirect_kind, redirect_target, trap_valid, trap_vector,
    output pc_out, pc_plus, pc_valid, misalign_err, misalign_addr, ras_overflow,
    output ras_underflow, ras_count
  );

endinterface

// File: rtl/pc_unit.sv
// Program counter with stall, jump/call/return redirect, trap redirect, a circular
// return-address stack and misaligned-target rejection.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INSTR_BYTES  = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input logic          clk,
  input logic          rst,
  pc_unit_if.slave     bus
);

  localparam int unsigned AlignBits = $clog2(INSTR_BYTES);
  localparam int unsigned PtrW      = $clog2(RAS_DEPTH);
  localparam int unsigned CntW      = $clog2(RAS_DEPTH + 1);

  localparam logic [1:0] KindCall = 2'b01;
  localparam logic [1:0] KindRet  = 2'b10;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q;
  logic            err_q, err_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // ptr_q is the next slot to write; the top of stack is ptr_q - 1 (mod depth).
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  logic            push;
  logic [XLEN-1:0] pc_plus;
  logic [PtrW-1:0] top_idx;
  logic            misaligned;
  logic            is_call;
  logic            is_ret;

  assign pc_plus    = pc_q + XLEN'(INSTR_BYTES);
  assign top_idx    = ptr_q - PtrW'(1);
  assign misaligned = |bus.redirect_target[AlignBits-1:0];
  assign is_call    = (bus.redirect_kind == KindCall);
  assign is_ret     = (bus.redirect_kind == KindRet);

  // Next-PC selection and RAS bookkeeping: trap > redirect > stall > sequential.
  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    push   = 1'b0;
    err_d  = 1'b0;
    addr_d = addr_q;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    if (bus.trap_valid) begin
      pc_d = bus.trap_vector;
    end else if (bus.redirect_valid) begin
      if (is_ret && (cnt_q != '0)) begin
        // Stacked addresses were aligned when pushed, so no check here.
        pc_d  = ras_q[top_idx];
        ptr_d = top_idx;
        cnt_d = cnt_q - CntW'(1);
      end else begin
        // A return on an empty stack reports underflow even if its fallback is rejected.
        unf_d = is_ret;
        if (misaligned) begin
          err_d  = 1'b1;
          addr_d = bus.redirect_target;
        end else begin
          pc_d = bus.redirect_target;
          if (is_call) begin
            push  = 1'b1;
            ptr_d = ptr_q + PtrW'(1);
            if (cnt_q == CntW'(RAS_DEPTH)) begin
              // Full: the write slot already holds the oldest entry, so it is overwritten.
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
      end
    end else if (!bus.stall) begin
      pc_d = pc_plus;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      err_q   <= err_d;
      addr_q  <= addr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // RAS storage; contents are don't-care after reset since ras_count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      ras_q[ptr_q] <= pc_plus;
    end
  end

  // Output drive.
  always_comb begin
    bus.pc_out        = pc_q;
    bus.pc_plus       = pc_plus;
    bus.pc_valid      = valid_q;
    bus.misalign_err  = err_q;
    bus.misalign_addr = addr_q;
    bus.ras_overflow  = ovf_q;
    bus.ras_underflow = unf_q;
    bus.ras_count     = cnt_q;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program counter for the next-generation fetch front end.
- Replaces the fixed +4 counter with:
  - a configurable reset vector and instruction width
  - stall, branch/jump redirect, trap redirect
  - a circular return-address stack (RAS) for call/return
  - misaligned-target rejection
- Sits between the fetch stage (consumes pc_out) and the branch/trap logic (drives redirects).

Parameters:
- XLEN, 32: PC width in bits.
- RESET_VECTOR, 32'h0000_0000: PC value loaded by rst.
- INSTR_BYTES, 4: sequential increment; power of two (2 or 4); alignment = log2(INSTR_BYTES) low bits zero.
- RAS_DEPTH, 4: return-address stack entries; power of two, 2..16.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- stall, in, 1: hold PC (sequential advance only).
- redirect_valid, in, 1: redirect request this cycle.
- redirect_kind, in, 2: 00 jump/branch, 01 call, 10 return, 11 treated as 00.
- redirect_target, in, XLEN: target for jump/call; fallback target for return on empty RAS.
- trap_valid, in, 1: trap redirect request.
- trap_vector, in, XLEN: trap handler address.
- pc_out, out, XLEN: current PC.
- pc_plus, out, XLEN: combinational pc_out + INSTR_BYTES, modulo 2^XLEN.
- pc_valid, out, 1: PC valid for fetch.
- misalign_err, out, 1: one-cycle pulse, rejected misaligned target.
- misalign_addr, out, XLEN: last rejected target, held until next error or reset.
- ras_overflow, out, 1: one-cycle pulse, call pushed onto a full RAS.
- ras_underflow, out, 1: one-cycle pulse, return issued on an empty RAS.
- ras_count, out, $clog2(RAS_DEPTH+1): valid RAS entries.

Behaviour:
- All state updates on posedge clk. Reset is synchronous and active-high on rst; clock is clk.
- Reset values:
  - pc_out = RESET_VECTOR
  - pc_valid = 0
  - misalign_err = 0, misalign_addr = 0
  - ras_overflow = 0, ras_underflow = 0
  - ras_count = 0, RAS pointer = 0; RAS contents don't-care.
- pc_valid goes to 1 on the first edge with rst low and stays 1 until the next reset.
- Next-PC priority, highest first; exactly one applies per cycle:
  1. rst.
  2. trap_valid: PC <= trap_vector. Alignment is not checked. The RAS is untouched and any simultaneous redirect is ignored.
  3. redirect_valid:
     - Kind 00: PC <= redirect_target.
     - Kind 01 (call): push pc_plus onto the RAS, then PC <= redirect_target.
     - Kind 10 (return), RAS not empty: PC <= top entry, pop.
     - Kind 10, RAS empty: PC <= redirect_target, ras_underflow pulses, ras_count stays 0.
  4. stall: PC holds.
  5. Otherwise: PC <= pc_plus, wrapping 2^XLEN-INSTR_BYTES -> 0 silently.
- Redirect and trap override stall.
- Alignment check, applied to the selected next PC for kinds 00/01 and for the return fallback:
  - If the low log2(INSTR_BYTES) bits are nonzero, the redirect is rejected: PC holds and the RAS is unchanged (no push or pop).
  - misalign_err pulses for one cycle; misalign_addr <= the rejected target.
  - A popped RAS value is always aligned; it needs no check.
- RAS is circular:
  - A push on full (ras_count == RAS_DEPTH) overwrites the oldest entry; ras_count stays RAS_DEPTH and ras_overflow pulses.
  - Push then pop returns values LIFO. After an overflow, the oldest surviving value is the (RAS_DEPTH)-th most recent push.
- Pulses deassert the cycle after assertion unless re-triggered.
- rst mid-operation discards all RAS contents and pending state on that edge.

Test Plan:
1. Reset, then 4 free-run cycles (defaults) -> pc_out = 0, 4, 8, 12, 16; pc_valid = 0 during rst, 1 thereafter.
2. Wrap-around: RESET_VECTOR = 32'hFFFF_FFF8, 3 cycles -> pc_out = FFFF_FFF8, FFFF_FFFC, 0000_0000.
3. Priority and stall:
   - stall at pc_out = 0x40 -> PC holds at 0x40.
   - stall + jump to 0x100 -> 0x100.
   - stall + jump to 0x200 + trap_vector = 0x80 -> 0x80, RAS unchanged.
4. RAS call/return:
   - Calls from 0x10, 0x20 to 0x400 -> ras_count = 2.
   - Return -> 0x24; return -> 0x14; third return with target 0x300 -> 0x300, ras_underflow = 1.
5. RAS overflow (RAS_DEPTH = 4): 5 calls from 0x0, 0x10, 0x20, 0x30, 0x40 -> overflow pulse on the 5th call. Five returns -> 0x44, 0x34, 0x24, 0x14, then underflow.
6. Misaligned jump to 0x102 at pc_out = 0x50 -> PC stays 0x50, misalign_err = 1 for 1 cycle, misalign_addr = 0x102, next cycle PC = 0x54. A misaligned call leaves ras_count unchanged.
